// File: rtl/dram_port_arbiter.sv
// Three-port arbiter in front of the single-port image DRAM: round-robin with bounded
// burst locking, one registered RAM command per cycle, read data tagged back to its port.
module dram_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int READ_LAT  = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [2:0]            lock,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*DATA_W-1:0]   req_wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_data,
    output logic                  ram_wren,
    input  logic [DATA_W-1:0]     ram_q,
    output logic                  busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic [1:0]        last_reg;
    logic [1:0]        owner_reg;
    logic [CNT_W-1:0]  burst_cnt_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_data_reg;
    logic              ram_wren_reg;
    logic [2:0]        rvalid_reg;
    logic              busy_reg;
    logic [READ_LAT:0] tag_valid_reg;
    logic [1:0]        tag_port_reg [READ_LAT+1];

    logic [ADDR_W-1:0] addr_arr  [3];
    logic [DATA_W-1:0] wdata_arr [3];
    logic [2:0]        owner_onehot;
    logic              lock_hold;
    logic [1:0]        rr_start;
    logic [2:0]        rr_gnt;
    logic [2:0]        gnt_next;
    logic              xfer;
    logic [1:0]        win;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              new_rd_valid;
    logic              busy_next;
    logic [2:0]        rvalid_next;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_port
            assign addr_arr[gi]    = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi]   = req_wdata[gi*DATA_W +: DATA_W];
            assign rvalid_next[gi] = tag_valid_reg[READ_LAT] && (tag_port_reg[READ_LAT] == 2'(gi));
        end
    endgenerate

    // First requester at or after 'start' in circular order, returned one-hot.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] start);
        logic [5:0] dbl;
        logic [2:0] rot;
        logic [2:0] pick;
        logic [5:0] back;
        dbl  = {r, r} >> start;
        rot  = dbl[2:0];
        pick = 3'b000;
        if (rot[0])      pick = 3'b001;
        else if (rot[1]) pick = 3'b010;
        else if (rot[2]) pick = 3'b100;
        back = {3'b000, pick} << start;
        return back[2:0] | back[5:3];
    endfunction

    always_comb begin
        owner_onehot = 3'b001 << owner_reg;
        lock_hold    = (|(owner_onehot & req & lock)) && (burst_cnt_reg < MAX_CNT);
        rr_start     = (last_reg == 2'd2) ? 2'd0 : last_reg + 2'd1;
        rr_gnt       = rr_pick(req, rr_start);
        gnt_next     = lock_hold ? owner_onehot : rr_gnt;
        gnt          = rst_n ? gnt_next : 3'b000;
    end

    always_comb begin
        xfer      = |gnt;
        win       = 2'd0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
                win       = 2'(i);
                sel_addr  = addr_arr[i];
                sel_wdata = wdata_arr[i];
                sel_we    = we[i];
            end
        end
        new_rd_valid = xfer && !sel_we;
        busy_next    = new_rd_valid || (|tag_valid_reg[READ_LAT-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg      <= 2'd2;
            owner_reg     <= 2'd0;
            burst_cnt_reg <= '0;
            ram_addr_reg  <= '0;
            ram_data_reg  <= '0;
            ram_wren_reg  <= 1'b0;
            rvalid_reg    <= 3'b000;
            busy_reg      <= 1'b0;
            tag_valid_reg <= '0;
            for (int k = 0; k <= READ_LAT; k++) tag_port_reg[k] <= 2'd0;
        end else begin
            if (xfer) begin
                last_reg      <= win;
                owner_reg     <= win;
                // Re-granting a saturated owner restarts its burst at 1.
                burst_cnt_reg <= (win == owner_reg && burst_cnt_reg < MAX_CNT)
                                 ? burst_cnt_reg + CNT_W'(1) : CNT_W'(1);
                ram_addr_reg  <= sel_addr;
                ram_data_reg  <= sel_wdata;
                ram_wren_reg  <= sel_we;
            end else begin
                ram_wren_reg  <= 1'b0;
            end
            tag_valid_reg   <= {tag_valid_reg[READ_LAT-1:0], new_rd_valid};
            tag_port_reg[0] <= win;
            for (int k = 1; k <= READ_LAT; k++) tag_port_reg[k] <= tag_port_reg[k-1];
            rvalid_reg <= rvalid_next;
            busy_reg   <= busy_next;
        end
    end

    assign ram_addr = ram_addr_reg;
    assign ram_data = ram_data_reg;
    assign ram_wren = ram_wren_reg;
    assign rvalid   = rvalid_reg;
    assign busy     = busy_reg;
    assign rdata    = ram_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed and randomized checks of dram_port_arbiter against a spec-level arbitration
// model, a scoreboard memory and a behavioural RAM with the matching read latency.
module tb_dram_port_arbiter;

    localparam int RL   = 1;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [2:0]  we = 3'b000;
    logic [2:0]  lock = 3'b000;
    logic [47:0] req_addr = '0;
    logic [23:0] req_wdata = '0;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [7:0]  rdata;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic [7:0]  ram_q;
    logic        busy;

    dram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .READ_LAT(RL), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: address sampled one edge after the arbiter registers it.
    logic [7:0] mem [0:65535] = '{default: 8'h00};
    logic [7:0] qpipe [0:RL];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        qpipe[0] <= mem[ram_addr];
        for (int k = 1; k <= RL; k++) qpipe[k] <= qpipe[k-1];
    end
    assign ram_q = qpipe[RL];

    typedef struct {
        int         port;
        logic [7:0] data;
        int         due;
    } rd_t;

    rd_t        pend[$];
    logic [7:0] sb [0:65535];
    int         n_tests = 0;
    int         n_fail = 0;
    int         edge_n = 0;
    int         m_last = 2;
    int         m_owner = 0;
    int         m_burst = 0;
    int         grants [3];
    int         win_last;
    logic [2:0] obs_gnt;
    logic [2:0] obs_rv;
    logic [7:0] obs_rd;
    logic       obs_wren;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lock rule first, otherwise first requester after the last winner.
    function automatic logic [2:0] model_gnt(input logic [2:0] r, input logic [2:0] l);
        logic [2:0] g;
        int p;
        g = 3'b000;
        if (r[m_owner] && l[m_owner] && m_burst < MAXB) begin
            g[m_owner] = 1'b1;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                p = (m_last + k) % 3;
                if (r[p] && g == 3'b000) g[p] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic set_cmd(input int p, input logic w, input logic [15:0] a, input logic [7:0] d);
        we[p] = w;
        req_addr[p*16 +: 16] = a;
        req_wdata[p*8 +: 8]  = d;
    endtask

    task automatic model_reset();
        m_last = 2;
        m_owner = 0;
        m_burst = 0;
        pend.delete();
    endtask

    // One clock cycle: check grant before the edge, advance the model, check outputs after.
    task automatic step();
        logic [2:0]  eg;
        logic [2:0]  erv;
        logic [7:0]  erd;
        logic [15:0] a;
        logic [7:0]  d;
        logic        isw;
        logic        ewren;
        int          w;
        #1;
        eg = model_gnt(req, lock);
        check("gnt", 32'(gnt), 32'(eg));
        obs_gnt = gnt;
        w = -1;
        a = '0;
        d = '0;
        isw = 1'b0;
        for (int p = 0; p < 3; p++) if (eg[p]) w = p;
        if (w >= 0) begin
            a = req_addr[w*16 +: 16];
            d = req_wdata[w*8 +: 8];
            isw = we[w];
        end
        @(posedge clk);
        edge_n++;
        ewren = 1'b0;
        if (w >= 0) begin
            m_burst = (w == m_owner && m_burst < MAXB) ? m_burst + 1 : 1;
            m_last  = w;
            m_owner = w;
            grants[w]++;
            if (isw) begin
                sb[a] = d;
                ewren = 1'b1;
            end else begin
                pend.push_back('{port: w, data: sb[a], due: edge_n + RL + 1});
            end
            $display("[TB] edge %0d port%0d %s addr=%04h data=%02h", edge_n, w,
                     isw ? "WR" : "RD", a, isw ? d : sb[a]);
        end
        win_last = w;
        #1;
        erv = 3'b000;
        erd = 8'h00;
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            erv = 3'(1 << pend[0].port);
            erd = pend[0].data;
            void'(pend.pop_front());
        end
        check("rvalid", 32'(rvalid), 32'(erv));
        if (erv != 3'b000) check("rdata", 32'(rdata), 32'(erd));
        check("ram_wren", 32'(ram_wren), 32'(ewren));
        if (w >= 0) begin
            check("ram_addr", 32'(ram_addr), 32'(a));
            if (isw) check("ram_data", 32'(ram_data), 32'(d));
        end
        check("busy", 32'(busy), 32'(pend.size() != 0));
        obs_rv   = rvalid;
        obs_rd   = rdata;
        obs_wren = ram_wren;
    endtask

    task automatic do_reset();
        req  = 3'b000;
        lock = 3'b000;
        step();  // lets any registered write reach the RAM first
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [2:0] hold;
        logic [2:0] rr_tab [6];
        logic [2:0] lk_tab [6];
        int gmin;
        int gmax;
        for (int i = 0; i < 65536; i++) sb[i] = 8'h00;
        for (int p = 0; p < 3; p++) grants[p] = 0;
        rr_tab = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        lk_tab = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};

        // Reset state
        #2;
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_ram_addr", 32'(ram_addr), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        do_reset();

        // Write then read-back of the same address from another port
        set_cmd(0, 1'b1, 16'h0010, 8'hA5);
        req = 3'b001;
        step();
        check("wr_wren", 32'(obs_wren), 32'(1));
        set_cmd(2, 1'b0, 16'h0010, 8'h00);
        req = 3'b100;
        step();
        check("rd_gnt", 32'(obs_gnt), 32'(3'b100));
        check("rd_wren", 32'(obs_wren), 32'(0));
        req = 3'b000;
        step();
        step();
        check("raw_rvalid", 32'(obs_rv), 32'(3'b100));
        check("raw_rdata", 32'(obs_rd), 32'(8'hA5));

        // Preload, then all-ports round robin reads
        for (int i = 0; i < 3; i++) begin
            set_cmd(0, 1'b1, 16'(16'h0020 + i), 8'(8'h11 * (i + 3)));
            req = 3'b001;
            step();
        end
        do_reset();
        for (int p = 0; p < 3; p++) set_cmd(p, 1'b0, 16'(16'h0020 + p), 8'h00);
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_seq", 32'(obs_gnt), 32'(rr_tab[i]));
        end
        req = 3'b000;
        repeat (RL + 2) step();

        // Burst lock with a competing port, then with the competitor idle
        do_reset();
        set_cmd(0, 1'b0, 16'h0021, 8'h00);
        set_cmd(1, 1'b0, 16'h0022, 8'h00);
        req  = 3'b011;
        lock = 3'b001;
        for (int i = 0; i < 6; i++) begin
            step();
            check("lock_seq", 32'(obs_gnt), 32'(lk_tab[i]));
        end
        req = 3'b001;
        for (int i = 0; i < 9; i++) begin
            step();
            check("lock_solo", 32'(obs_gnt), 32'(3'b001));
        end

        // Reset one cycle before a read returns
        do_reset();
        set_cmd(0, 1'b1, 16'h00FF, 8'h3C);
        set_cmd(1, 1'b0, 16'h0034, 8'h00);
        req = 3'b011;
        step();
        req = 3'b010;
        step();
        check("pre_rst_gnt", 32'(obs_gnt), 32'(3'b010));
        req = 3'b000;
        step();
        rst_n = 1'b0;
        req = 3'b111;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_addr", 32'(ram_addr), 32'(0));
        check("mid_rst_data", 32'(ram_data), 32'(0));
        check("mid_rst_wren", 32'(ram_wren), 32'(0));
        repeat (2) begin
            @(posedge clk);
            #1;
            check("mid_rst_rvalid", 32'(rvalid), 32'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int p = 0; p < 3; p++) set_cmd(p, 1'b0, 16'(16'h0040 + p), 8'h00);
        step();
        check("post_rst_first", 32'(obs_gnt), 32'(3'b001));
        req = 3'b000;
        repeat (RL + 2) step();

        // Fairness with all ports requesting unlocked
        do_reset();
        for (int p = 0; p < 3; p++) grants[p] = 0;
        for (int p = 0; p < 3; p++)
            set_cmd(p, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 8'($urandom));
        req = 3'b111;
        for (int c = 0; c < 300; c++) begin
            step();
            if (win_last >= 0)
                set_cmd(win_last, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 8'($urandom));
        end
        gmin = grants[0];
        gmax = grants[0];
        for (int p = 1; p < 3; p++) begin
            if (grants[p] < gmin) gmin = grants[p];
            if (grants[p] > gmax) gmax = grants[p];
        end
        check("fair_spread_ok", 32'(gmax - gmin <= 1), 32'(1));

        // Random mixed traffic with locks, abandoned requests and address collisions
        hold = 3'b000;
        for (int c = 0; c < 10000; c++) begin
            for (int p = 0; p < 3; p++) begin
                if (!hold[p]) begin
                    if ($urandom_range(0, 9) < 7) begin
                        hold[p] = 1'b1;
                        set_cmd(p, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 8'($urandom));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    hold[p] = 1'b0;
                end
                lock[p] = ($urandom_range(0, 3) == 0);
            end
            req = hold;
            step();
            if (win_last >= 0) hold[win_last] = 1'b0;
        end
        req = 3'b000;
        lock = 3'b000;
        repeat (RL + 2) step();
        check("reads_all_returned", 32'(pend.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
